// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - multi-channel programmable clock divider with toggle/pulse modes and global resync
module clock_divider_multi #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 25,
    parameter int DEFAULT_DIV  = 12500000,
    parameter int DEFAULT_MODE = 1,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_25MHz,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              resync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [CNT_W-1:0]  div_r   [NUM_CH];
    logic [CNT_W-1:0]  count_r [NUM_CH];
    logic [NUM_CH-1:0] mode_r;

    // Priority per channel: reset > own config write > resync > counting.
    // Out-of-range cfg_ch never matches any loop index, so such writes are dropped.
    always_ff @(posedge clk_25MHz) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                div_r[i]   <= CNT_W'(DEFAULT_DIV);
                mode_r[i]  <= 1'(DEFAULT_MODE);
                count_r[i] <= '0;
                clk_out[i] <= 1'b0;
                tick[i]    <= 1'b0;
            end else if (cfg_we && (int'(cfg_ch) == i)) begin
                div_r[i]   <= cfg_div;
                mode_r[i]  <= cfg_mode;
                count_r[i] <= '0;
                clk_out[i] <= 1'b0;
                tick[i]    <= 1'b0;
            end else if (resync) begin
                count_r[i] <= '0;
                clk_out[i] <= 1'b0;
                tick[i]    <= 1'b0;
            end else if ((div_r[i] == '0) || !ch_en[i]) begin
                tick[i] <= 1'b0;
            end else if (count_r[i] >= (div_r[i] - CNT_W'(1))) begin
                // >= so a shrunk divisor fires on the next cycle instead of wrapping
                count_r[i] <= '0;
                if (mode_r[i]) begin
                    clk_out[i] <= ~clk_out[i];
                end
                tick[i] <= ~mode_r[i];
            end else begin
                count_r[i] <= count_r[i] + CNT_W'(1);
                tick[i]    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb/tb_clock_divider_multi.sv - randomized bench for clock_divider_multi against an elapsed-cycle reference model
module tb_clock_divider_multi;

    localparam int NCH   = 6;
    localparam int CW    = 8;
    localparam int DDIV  = 4;
    localparam int DMODE = 1;
    localparam int CHW   = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] ch_en;
    logic           resync;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_mode;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    clock_divider_multi #(
        .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV), .DEFAULT_MODE(DMODE)
    ) dut (
        .clk_25MHz(clk), .reset(reset), .ch_en(ch_en), .resync(resync),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
        .clk_out(clk_out), .tick(tick)
    );

    always #20 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: each channel remembers how many enabled cycles have elapsed since
    // its last restart; outputs follow from that count by plain arithmetic.
    int     m_div [NCH];
    bit     m_mode[NCH];
    longint m_el  [NCH];
    bit     m_adv [NCH];

    function automatic bit exp_clk(int i);
        if (!m_mode[i] || m_div[i] == 0) return 1'b0;
        return bit'((m_el[i] / m_div[i]) % 2);
    endfunction

    function automatic bit exp_tick(int i);
        if (m_mode[i] || m_div[i] == 0 || !m_adv[i]) return 1'b0;
        return (m_el[i] % m_div[i]) == 0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                m_div[i] = DDIV; m_mode[i] = DMODE; m_el[i] = 0; m_adv[i] = 0;
            end else if (cfg_we && int'(cfg_ch) == i) begin
                m_div[i] = int'(cfg_div); m_mode[i] = cfg_mode; m_el[i] = 0; m_adv[i] = 0;
            end else if (resync) begin
                m_el[i] = 0; m_adv[i] = 0;
            end else if (m_div[i] == 0 || !ch_en[i]) begin
                m_adv[i] = 0;
            end else begin
                m_el[i]++; m_adv[i] = 1;
            end
        end
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("clk_out[%0d]", i), 32'(clk_out[i]), 32'(exp_clk(i)));
            check($sformatf("tick[%0d]", i), 32'(tick[i]), 32'(exp_tick(i)));
        end
    endtask

    task automatic idle();
        reset = 0; resync = 0; cfg_we = 0; cfg_ch = '0; cfg_div = '0; cfg_mode = 0;
    endtask

    task automatic write(input int ch, input int dv, input bit md);
        cfg_we = 1; cfg_ch = CHW'(ch); cfg_div = CW'(dv); cfg_mode = md;
        cycle();
        cfg_we = 0;
    endtask

    task automatic reset_and_first_rise(input string tag);
        reset = 1;
        cycle();
        check({tag, "_rst_clk"}, 32'(clk_out), 32'(0));
        check({tag, "_rst_tick"}, 32'(tick), 32'(0));
        reset = 0;
        ch_en = '1;
        for (int k = 0; k < 3; k++) cycle();
        check({tag, "_before_rise"}, 32'(clk_out), 32'(0));
        cycle();
        check({tag, "_first_rise"}, 32'(clk_out), 32'({NCH{1'b1}}));
        for (int k = 0; k < 4; k++) cycle();
        check({tag, "_first_fall"}, 32'(clk_out), 32'(0));
        check({tag, "_tick_quiet"}, 32'(tick), 32'(0));
    endtask

    initial begin
        idle();
        ch_en = '1;
        reset_and_first_rise("init");

        // Pulse mode on ch1, div 3
        write(1, 3, 0);
        cycle(); cycle();
        check("pulse_pre", 32'(tick[1]), 32'(0));
        cycle();
        check("pulse_first", 32'(tick[1]), 32'(1));
        cycle();
        check("pulse_after", 32'(tick[1]), 32'(0));
        for (int k = 0; k < 8; k++) cycle();

        // Pause ch2 for 5 cycles, halt ch3 with div 0
        ch_en[2] = 0;
        for (int k = 0; k < 5; k++) cycle();
        ch_en[2] = 1;
        write(3, 0, 1);
        for (int k = 0; k < 12; k++) cycle();

        // Shrink ch0 divisor mid-count
        write(0, 10, 1);
        for (int k = 0; k < 6; k++) cycle();
        write(0, 2, 1);
        for (int k = 0; k < 9; k++) cycle();

        // Config and resync together, then out-of-range channel writes
        cfg_we = 1; cfg_ch = 3'd1; cfg_div = 8'd5; cfg_mode = 1; resync = 1;
        cycle();
        idle();
        for (int k = 0; k < 12; k++) cycle();
        write(7, 1, 0);
        write(6, 1, 0);
        for (int k = 0; k < 6; k++) cycle();
        pulse_one_check: begin
            write(4, 1, 0);
            for (int k = 0; k < 3; k++) cycle();
            check("pulse_div1_hold", 32'(tick[4]), 32'(1));
        end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset  = ($urandom_range(0, 499) == 0);
            resync = ($urandom_range(0, 39) == 0);
            cfg_we = ($urandom_range(0, 15) == 0);
            cfg_ch = CHW'($urandom_range(0, 7));
            cfg_div = CW'($urandom_range(0, 9));
            cfg_mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < NCH; i++) ch_en[i] = ($urandom_range(0, 7) != 0);
            cycle();
        end

        idle();
        reset_and_first_rise("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
